// File: rtl/phy_rx_align_if.sv
// Bundle between the serial receiver/aligner and whoever feeds it bits and
// consumes the recovered lane words.
interface phy_rx_align_if #(
    parameter int DATA_W = 8,
    parameter int LANES  = 4
);
    // There is no backpressure. valid_out[i] is a single-cycle pulse on the
    // edge where lane i of data_out takes a new word. The consumer must
    // capture that word while the pulse is high. A lane holds its value
    // until it is written again.
    logic                    datos_paralelo_serial;
    logic [LANES*DATA_W-1:0] data_out;
    logic [LANES-1:0]        valid_out;
    logic                    idle_out;
    logic                    locked;

    modport master (
        input  datos_paralelo_serial,
        output data_out,
        output valid_out,
        output idle_out,
        output locked
    );

    modport slave (
        output datos_paralelo_serial,
        input  data_out,
        input  valid_out,
        input  idle_out,
        input  locked
    );
endinterface

// File: rtl/phy_rx_align.sv
// Serial-to-parallel receiver. It hunts for a comma symbol, locks after enough
// aligned commas and then deals the following data words round-robin across lanes.
module phy_rx_align #(
    parameter int                DATA_W     = 8,
    parameter int                LANES      = 4,
    parameter logic [DATA_W-1:0] COMMA      = 8'hBC,
    parameter int                LOCK_COUNT = 4,
    parameter int                LOSS_COUNT = 2
) (
    input  logic                clk_32f,
    input  logic                rst,
    phy_rx_align_if.master      rx,
    output logic [1:0]          state_dbg
);

    localparam int CNT_W  = $clog2(DATA_W);
    localparam int CC_W   = $clog2(LOCK_COUNT + 1);
    localparam int MC_W   = $clog2(LOSS_COUNT + 1);
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_W - 1);
    localparam logic [CC_W-1:0]   LOCK_CC   = CC_W'(LOCK_COUNT);
    localparam logic [MC_W-1:0]   LOSS_MC   = MC_W'(LOSS_COUNT);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_W-1:0]       sr_q;
    logic [DATA_W-1:0]       sr_next;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [CC_W-1:0]         comma_cnt_q, comma_cnt_d;
    logic [MC_W-1:0]         miss_cnt_q, miss_cnt_d;
    logic [LANE_W-1:0]       lane_ptr_q, lane_ptr_d;
    logic [LANES*DATA_W-1:0] data_q, data_d;
    logic [LANES-1:0]        valid_q, valid_d;
    logic                    idle_q, idle_d;
    logic                    locked_q, locked_d;

    logic                    is_comma;
    logic                    boundary;
    logic [CC_W-1:0]         comma_inc;
    logic [MC_W-1:0]         miss_inc;
    logic [LANE_W-1:0]       lane_inc;

    // Every decision looks at the window that includes the bit arriving on this edge.
    assign sr_next   = {sr_q[DATA_W-2:0], rx.datos_paralelo_serial};
    assign is_comma  = (sr_next == COMMA);
    assign boundary  = (bit_cnt_q == LAST_BIT);
    assign comma_inc = comma_cnt_q + 1'b1;
    assign miss_inc  = miss_cnt_q + 1'b1;
    assign lane_inc  = (lane_ptr_q == LAST_LANE) ? '0 : lane_ptr_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        comma_cnt_d = comma_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        lane_ptr_d  = lane_ptr_q;
        data_d      = data_q;
        valid_d     = '0;
        idle_d      = idle_q;
        locked_d    = locked_q;

        unique case (state_q)
            HUNT: begin
                idle_d    = 1'b1;
                locked_d  = 1'b0;
                bit_cnt_d = '0;
                if (is_comma) begin
                    comma_cnt_d = CC_W'(1);
                    if (LOCK_COUNT == 1) begin
                        state_d    = LOCKED;
                        locked_d   = 1'b1;
                        lane_ptr_d = '0;
                        miss_cnt_d = '0;
                    end else begin
                        state_d = SYNC;
                    end
                end
            end

            SYNC: begin
                idle_d = 1'b1;
                if (boundary) begin
                    bit_cnt_d = '0;
                    if (is_comma) begin
                        comma_cnt_d = comma_inc;
                        if (comma_inc == LOCK_CC) begin
                            state_d    = LOCKED;
                            locked_d   = 1'b1;
                            lane_ptr_d = '0;
                            miss_cnt_d = '0;
                        end
                    end else begin
                        state_d     = HUNT;
                        comma_cnt_d = '0;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end

            LOCKED: begin
                if (boundary) begin
                    bit_cnt_d = '0;
                    if (is_comma) begin
                        idle_d     = 1'b1;
                        lane_ptr_d = '0;
                        miss_cnt_d = '0;
                    end else begin
                        data_d[int'(lane_ptr_q)*DATA_W +: DATA_W] = sr_next;
                        valid_d[lane_ptr_q] = 1'b1;
                        idle_d     = 1'b0;
                        lane_ptr_d = lane_inc;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    // A comma seen off the word grid means the alignment has slipped.
                    if (is_comma) begin
                        if (miss_inc == LOSS_MC) begin
                            state_d     = HUNT;
                            locked_d    = 1'b0;
                            idle_d      = 1'b1;
                            lane_ptr_d  = '0;
                            miss_cnt_d  = '0;
                            comma_cnt_d = '0;
                            bit_cnt_d   = '0;
                        end else begin
                            miss_cnt_d = miss_inc;
                        end
                    end
                end
            end

            default: begin
                state_d     = HUNT;
                idle_d      = 1'b1;
                locked_d    = 1'b0;
                bit_cnt_d   = '0;
                comma_cnt_d = '0;
                miss_cnt_d  = '0;
                lane_ptr_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_32f or posedge rst) begin
        if (rst) begin
            state_q     <= HUNT;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            comma_cnt_q <= '0;
            miss_cnt_q  <= '0;
            lane_ptr_q  <= '0;
            data_q      <= '0;
            valid_q     <= '0;
            idle_q      <= 1'b1;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_next;
            bit_cnt_q   <= bit_cnt_d;
            comma_cnt_q <= comma_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            lane_ptr_q  <= lane_ptr_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            idle_q      <= idle_d;
            locked_q    <= locked_d;
        end
    end

    assign rx.data_out  = data_q;
    assign rx.valid_out = valid_q;
    assign rx.idle_out  = idle_q;
    assign rx.locked    = locked_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_phy_rx_align.sv
// Bench for phy_rx_align: symbol tables, hand-built corner sequences and a random
// bit stream checked every edge against a bit-level reference model.
module tb_phy_rx_align;

    localparam int          W  = 8;
    localparam int          L  = 4;
    localparam logic [7:0]  K  = 8'hBC;
    localparam int          W2 = 10;
    localparam int          L2 = 2;
    localparam logic [9:0]  K2 = 10'h17C;
    localparam int          M_HUNT = 0, M_SYNC = 1, M_LOCKED = 2;

    logic clk_32f = 1'b0;
    logic rst     = 1'b0;
    always #5 clk_32f = ~clk_32f;

    phy_rx_align_if #(.DATA_W(W),  .LANES(L))  bus   ();
    phy_rx_align_if #(.DATA_W(W2), .LANES(L2)) bus10 ();
    logic [1:0] state_dbg, state_dbg10;

    phy_rx_align #(.DATA_W(W), .LANES(L), .COMMA(K), .LOCK_COUNT(4), .LOSS_COUNT(2)) u_dut (
        .clk_32f(clk_32f), .rst(rst), .rx(bus.master), .state_dbg(state_dbg));

    phy_rx_align #(.DATA_W(W2), .LANES(L2), .COMMA(K2), .LOCK_COUNT(2), .LOSS_COUNT(2)) u_dut10 (
        .clk_32f(clk_32f), .rst(rst), .rx(bus10.master), .state_dbg(state_dbg10));

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (bit history + word phase) ----------------
    int         m_mode, m_phase, m_good, m_miss, m_next;
    bit         m_hist[$];
    logic [7:0] m_lane[L];
    logic [3:0] m_valid;
    logic       m_idle, m_locked;
    logic [W-1:0] exp_q[$];

    function automatic void model_reset();
        m_hist.delete();
        for (int i = 0; i < W; i++) m_hist.push_back(1'b0);
        m_mode = M_HUNT; m_phase = 0; m_good = 0; m_miss = 0; m_next = 0;
        for (int i = 0; i < L; i++) m_lane[i] = 8'h00;
        m_valid = 4'h0; m_idle = 1'b1; m_locked = 1'b0;
    endfunction

    function automatic void model_step(input bit b);
        int  win;
        bit  at_word;
        m_hist.push_back(b);
        void'(m_hist.pop_front());
        win = 0;
        foreach (m_hist[i]) win = win * 2 + int'(m_hist[i]);
        m_valid = 4'h0;
        if (m_mode == M_HUNT) begin
            if (win == int'(K)) begin
                m_phase = 0; m_good = 1; m_mode = M_SYNC;
            end
        end else begin
            m_phase++;
            at_word = (m_phase == W);
            if (at_word) m_phase = 0;
            if (m_mode == M_SYNC) begin
                if (at_word) begin
                    if (win == int'(K)) begin
                        m_good++;
                        if (m_good == 4) begin
                            m_mode = M_LOCKED; m_locked = 1'b1; m_next = 0; m_miss = 0;
                        end
                    end else begin
                        m_mode = M_HUNT; m_good = 0;
                    end
                end
            end else if (at_word) begin
                if (win == int'(K)) begin
                    m_idle = 1'b1; m_next = 0; m_miss = 0;
                end else begin
                    m_lane[m_next]  = 8'(win);
                    m_valid[m_next] = 1'b1;
                    m_idle = 1'b0;
                    exp_q.push_back(8'(win));
                    m_next = (m_next + 1) % L;
                end
            end else if (win == int'(K)) begin
                m_miss++;
                if (m_miss == 2) begin
                    m_mode = M_HUNT; m_locked = 1'b0; m_idle = 1'b1;
                    m_next = 0; m_miss = 0; m_good = 0;
                end
            end
        end
    endfunction

    // ---------------- per-edge monitor / scoreboard ----------------
    logic        mon_bit, mon_rst;
    logic [31:0] mon_data;
    always @(posedge clk_32f) begin
        mon_bit = bus.datos_paralelo_serial;
        mon_rst = rst;
        #1;
        if (mon_rst) model_reset();
        else         model_step(mon_bit);
        for (int i = 0; i < L; i++) mon_data[i*8 +: 8] = m_lane[i];
        check("mon_valid",  bus.valid_out, m_valid);
        check("mon_locked", bus.locked,    m_locked);
        check("mon_idle",   bus.idle_out,  m_idle);
        check("mon_state",  state_dbg,     m_mode);
        check("mon_data",   bus.data_out,  mon_data);
        for (int i = 0; i < L; i++) begin
            if (bus.valid_out[i]) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL sb_unexpected lane=%0d actual=%0h expected=none", i, bus.data_out[i*8 +: 8]);
                end else begin
                    check("sb_data", bus.data_out[i*8 +: 8], exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_bit(input logic b);
        bus.datos_paralelo_serial = b;
        @(posedge clk_32f); #1;
    endtask

    task automatic send8(input logic [7:0] s);
        for (int i = 7; i >= 0; i--) send_bit(s[i]);
    endtask

    task automatic send10(input logic [9:0] s);
        for (int i = 9; i >= 0; i--) begin
            bus10.datos_paralelo_serial = s[i];
            @(posedge clk_32f); #1;
        end
    endtask

    task automatic do_reset();
        bus.datos_paralelo_serial   = 1'b0;
        bus10.datos_paralelo_serial = 1'b0;
        rst = 1'b1;
        @(posedge clk_32f); #1;
        @(posedge clk_32f); #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic        rst_before;
        logic [7:0]  sym;
        logic [3:0]  exp_valid;
        logic        exp_locked;
        logic        exp_idle;
        logic [31:0] exp_data;
    } vec_t;
    vec_t vecs[19];

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // lock sequence, lane dealing, idle on comma, then a failed SYNC
        vecs[0]  = '{1'b1, 8'hF2, 4'b0000, 1'b0, 1'b1, 32'h00000000};
        vecs[1]  = '{1'b0, 8'h15, 4'b0000, 1'b0, 1'b1, 32'h00000000};
        vecs[2]  = '{1'b0, 8'hBC, 4'b0000, 1'b0, 1'b1, 32'h00000000};
        vecs[3]  = '{1'b0, 8'hBC, 4'b0000, 1'b0, 1'b1, 32'h00000000};
        vecs[4]  = '{1'b0, 8'hBC, 4'b0000, 1'b0, 1'b1, 32'h00000000};
        vecs[5]  = '{1'b0, 8'hBC, 4'b0000, 1'b1, 1'b1, 32'h00000000};
        vecs[6]  = '{1'b0, 8'hDD, 4'b0001, 1'b1, 1'b0, 32'h000000DD};
        vecs[7]  = '{1'b0, 8'h45, 4'b0010, 1'b1, 1'b0, 32'h000045DD};
        vecs[8]  = '{1'b0, 8'hAA, 4'b0100, 1'b1, 1'b0, 32'h00AA45DD};
        vecs[9]  = '{1'b0, 8'h13, 4'b1000, 1'b1, 1'b0, 32'h13AA45DD};
        vecs[10] = '{1'b0, 8'hDD, 4'b0001, 1'b1, 1'b0, 32'h13AA45DD};
        vecs[11] = '{1'b0, 8'hDD, 4'b0010, 1'b1, 1'b0, 32'h13AADDDD};
        vecs[12] = '{1'b0, 8'h45, 4'b0100, 1'b1, 1'b0, 32'h1345DDDD};
        vecs[13] = '{1'b0, 8'hBC, 4'b0000, 1'b1, 1'b1, 32'h1345DDDD};
        vecs[14] = '{1'b0, 8'hAA, 4'b0001, 1'b1, 1'b0, 32'h1345DDAA};
        vecs[15] = '{1'b1, 8'hBC, 4'b0000, 1'b0, 1'b1, 32'h00000000};
        vecs[16] = '{1'b0, 8'hBC, 4'b0000, 1'b0, 1'b1, 32'h00000000};
        vecs[17] = '{1'b0, 8'hBC, 4'b0000, 1'b0, 1'b1, 32'h00000000};
        vecs[18] = '{1'b0, 8'hDD, 4'b0000, 1'b0, 1'b1, 32'h00000000};

        model_reset();
        bus.datos_paralelo_serial   = 1'b0;
        bus10.datos_paralelo_serial = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_data",   bus.data_out,  32'h0);
        check("rst_valid",  bus.valid_out, 4'h0);
        check("rst_idle",   bus.idle_out,  1'b1);
        check("rst_locked", bus.locked,    1'b0);

        for (int i = 0; i < 19; i++) begin
            if (vecs[i].rst_before) do_reset();
            send8(vecs[i].sym);
            check($sformatf("vec%0d_valid", i),  bus.valid_out, vecs[i].exp_valid);
            check($sformatf("vec%0d_locked", i), bus.locked,    vecs[i].exp_locked);
            check($sformatf("vec%0d_idle", i),   bus.idle_out,  vecs[i].exp_idle);
            check($sformatf("vec%0d_data", i),   bus.data_out,  vecs[i].exp_data);
        end
        check("sync_fail_state", state_dbg, M_HUNT);

        // slip by one bit: two off-grid commas drop lock, then relock
        do_reset();
        repeat (4) send8(K);
        check("slip_pre_locked", bus.locked, 1'b1);
        send8(8'hDD);
        check("slip_pre_valid", bus.valid_out, 4'b0001);
        send_bit(1'b0);
        send8(K);
        check("slip_one_hit_locked", bus.locked, 1'b1);
        send8(K);
        check("slip_lost_locked", bus.locked,   1'b0);
        check("slip_lost_state",  state_dbg,    M_HUNT);
        check("slip_lost_idle",   bus.idle_out, 1'b1);
        check("slip_lanes12",     bus.data_out[23:8], 16'h5E5E);
        repeat (4) send8(K);
        check("relock_locked", bus.locked, 1'b1);
        send8(8'h77);
        check("relock_valid", bus.valid_out, 4'b0001);
        check("relock_lane0", bus.data_out[7:0], 8'h77);

        // asynchronous reset while the 5th bit of a data word is on the line
        for (int i = 7; i >= 4; i--) send_bit(8'hDD >> i);
        bus.datos_paralelo_serial = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("async_data",   bus.data_out,  32'h0);
        check("async_valid",  bus.valid_out, 4'h0);
        check("async_idle",   bus.idle_out,  1'b1);
        check("async_locked", bus.locked,    1'b0);
        check("async_state",  state_dbg,     M_HUNT);
        @(posedge clk_32f); #1;
        rst = 1'b0;
        repeat (4) send8(K);
        check("post_rst_locked", bus.locked, 1'b1);
        send8(8'h3C);
        check("post_rst_valid", bus.valid_out, 4'b0001);
        check("post_rst_data",  bus.data_out,  32'h0000003C);

        // randomized stream with comma bursts, stray commas and bit slips
        do_reset();
        repeat (4) send8(K);
        for (int n = 0; n < 400; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 10)      repeat ($urandom_range(4, 6)) send8(K);
            else if (r < 25) send8(K);
            else if (r < 30) repeat ($urandom_range(1, 3)) send_bit(1'($urandom_range(0, 1)));
            else             send8(8'($urandom_range(0, 255)));
        end

        // wider symbol, two lanes, lock after two commas
        do_reset();
        send10(K2);
        check("w10_first_locked", bus10.locked, 1'b0);
        check("w10_first_state",  state_dbg10,  M_SYNC);
        send10(K2);
        check("w10_locked", bus10.locked,   1'b1);
        check("w10_idle",   bus10.idle_out, 1'b1);
        send10(10'h2A5);
        check("w10_v0",   bus10.valid_out, 2'b01);
        check("w10_d0",   bus10.data_out,  20'h002A5);
        send10(10'h15A);
        check("w10_v1",   bus10.valid_out, 2'b10);
        check("w10_d1",   bus10.data_out,  20'h56AA5);
        send10(10'h0F0);
        check("w10_v2",   bus10.valid_out, 2'b01);
        check("w10_d2",   bus10.data_out,  20'h568F0);
        check("w10_idle0", bus10.idle_out, 1'b0);

        check("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/phy_rx_align.md
PHY_RX_ALIGN -- requirements
Module: phy_rx_align

Interface
REQ-001 Parameter DATA_W, default 8, symbol width in bits (>=4).
REQ-002 Parameter LANES, default 4, number of parallel output lanes (>=1).
REQ-003 Parameter COMMA, default 8'hBC, DATA_W-bit alignment/idle symbol.
REQ-004 Parameter LOCK_COUNT, default 4, consecutive aligned commas required to lock (>=1).
REQ-005 Parameter LOSS_COUNT, default 2, consecutive misaligned comma hits that drop lock (>=1).
REQ-006 One clock; reset is asynchronous and active-high.
REQ-007 clk_32f  input  1  serial bit clock; all state changes on its rising edge.
REQ-008 rst  input  1  asynchronous active-high reset.
REQ-009 datos_paralelo_serial  input  1  serial data, MSB of each symbol first.
REQ-010 data_out  output  LANES*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W].
REQ-011 valid_out  output  LANES  one-cycle pulse per lane when that lane's data_out updates.
REQ-012 idle_out  output  1  high when unlocked or the last locked symbol was COMMA.
REQ-013 locked  output  1  high in state LOCKED.

Function
REQ-014 Shift register sr (DATA_W bits); each edge sr_next = {sr[DATA_W-2:0], datos_paralelo_serial}; all comparisons use sr_next.
REQ-015 Bit counter bit_cnt (0..DATA_W-1); a word boundary occurs on the edge where bit_cnt == DATA_W-1, then bit_cnt wraps to 0.
REQ-016 States HUNT, SYNC, LOCKED; reset state HUNT.
REQ-017 HUNT: bit_cnt ignored; when sr_next == COMMA, set bit_cnt=0, comma_cnt=1, go SYNC (LOCKED directly if LOCK_COUNT==1).
REQ-018 SYNC: at each boundary, sr_next == COMMA -> comma_cnt+1, go LOCKED when it reaches LOCK_COUNT; else -> HUNT, comma_cnt=0.
REQ-019 SYNC/HUNT: valid_out stays 0, idle_out stays 1, data_out holds.
REQ-020 LOCKED boundary with COMMA: idle_out=1, lane_ptr=0, miss_cnt=0, no valid.
REQ-021 LOCKED boundary with non-COMMA: data_out lane lane_ptr <= sr_next, valid_out[lane_ptr]=1, idle_out=0, lane_ptr increments modulo LANES.
REQ-022 Outputs are registered and update on the same edge that samples the symbol's last bit; valid_out is 0 on every other edge.
REQ-023 LOCKED non-boundary edge with sr_next == COMMA: miss_cnt+1; reaching LOSS_COUNT -> HUNT, locked=0, idle_out=1, lane_ptr=0.
REQ-024 Transition LOCKED->HUNT on the same edge a hit is counted; that edge's sr_next may itself start SYNC only on a later edge.
REQ-025 Non-comma data words never alter miss_cnt; miss_cnt and lane_ptr widths sized by $clog2 with LANES==1 pinned to lane 0.
REQ-026 Lanes not written keep their previous value indefinitely.

Reset
REQ-027 rst high asynchronously forces: state HUNT, sr=0, bit_cnt=0, comma_cnt=0, miss_cnt=0, lane_ptr=0, data_out=0, valid_out=0, idle_out=1, locked=0.
REQ-028 Reset mid-symbol discards the partial symbol; after release, the block hunts from the next bit.
REQ-029 Release of rst is synchronous to clk_32f by the environment; no output glitches on release.

Verification
REQ-030 Default params; send F2,15, then BC x4, then DD,45,AA,13,DD -> locked rises on 4th BC's last bit; valid_out 0001/0010/0100/1000/0001 with data_out lanes DD,45,AA,13 then lane0=DD; idle_out 0 after DD.
REQ-031 BC x3 then DD -> returns to HUNT at DD's last bit, no valid_out ever, idle_out stays 1.
REQ-032 Locked; send DD,45,BC,AA -> idle_out pulses high at BC, AA lands on lane0 with valid_out=0001.
REQ-033 Locked; insert one extra 0 bit before a BC,BC pair -> two misaligned hits, locked falls, state HUNT; subsequent aligned BC x4 relocks and lane0 receives next data.
REQ-034 Assert rst during 5th bit of a locked data symbol -> all outputs at reset values immediately; no valid_out for that symbol.
REQ-035 DATA_W=10, LANES=2, COMMA=10'h17C, LOCK_COUNT=2 -> lock after two aligned commas; data alternates lane0/lane1.
